// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues fixed-latency reads to
// instruction memory and pulses IF_kick_up when the fetched word is valid.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_mem_req,
  output logic [31:0] inst_mem_addr,
  output logic        IF_kick_up,
  output logic [31:0] fetch_pc,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [31:0] PC_ALIGN  = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_INIT   = RESET_PC & PC_ALIGN;
  localparam logic [2:0]  WAIT_INIT = 3'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  wait_q, wait_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    inst_mem_req = 1'b0;
    IF_kick_up   = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        inst_mem_req = 1'b1;
        wait_d       = WAIT_INIT;
        state_d      = WAIT;
      end
      WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 3'd1;
        end else if (!stall) begin
          IF_kick_up = 1'b1;
          pc_d       = pc_q + 32'd4;
          cnt_d      = cnt_q + 32'd1;
          state_d    = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          IF_kick_up = 1'b1;
          pc_d       = pc_q + 32'd4;
          cnt_d      = cnt_q + 32'd1;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything decoded above, discarding any delivery.
    if (redirect_valid) begin
      IF_kick_up = 1'b0;
      pc_d       = redirect_pc & PC_ALIGN;
      cnt_d      = cnt_q;
      wait_d     = '0;
      state_d    = REQ;
    end
  end

  assign inst_mem_addr = pc_q;
  assign fetch_pc      = pc_q;
  assign inst_count    = cnt_q;

  a_req_only_in_req : assert property (@(posedge clk) disable iff (reset)
    inst_mem_req |-> (state_q == REQ));
  a_no_kick_on_redirect : assert property (@(posedge clk) disable iff (reset)
    IF_kick_up |-> !redirect_valid);
  a_no_back_to_back_kick : assert property (@(posedge clk) disable iff (reset)
    IF_kick_up |=> !IF_kick_up);

endmodule
